// File: rtl/bht_predictor_if.sv
// ID/EX-side signal bundle for the branch history table; master drives the
// pipeline controls and resolutions, slave (the predictor) returns predictions.
interface bht_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic                id_is_branch;
    logic [PC_WIDTH-1:0] id_pc;
    logic                stall;
    logic                flush;
    logic                ex_update;
    logic                ex_taken;
    logic                pred_taken;
    logic                ex_pred_taken;
    logic                mispredict;

    modport master (
        output id_is_branch,
        output id_pc,
        output stall,
        output flush,
        output ex_update,
        output ex_taken,
        input  pred_taken,
        input  ex_pred_taken,
        input  mispredict
    );

    modport slave (
        input  id_is_branch,
        input  id_pc,
        input  stall,
        input  flush,
        input  ex_update,
        input  ex_taken,
        output pred_taken,
        output ex_pred_taken,
        output mispredict
    );
endinterface

// File: rtl/bht_predictor.sv
// Per-PC saturating-counter branch predictor: combinational ID read, EX-aligned prediction, update at resolution.
// Define BHT_GSHARE_EN to XOR the table index with a non-speculative global history register.
module bht_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int CTR_INIT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    bht_predictor_if.slave   bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    logic [CTR_BITS-1:0]   ctr [ENTRIES];
    logic [INDEX_BITS-1:0] pc_idx;
    logic [INDEX_BITS-1:0] id_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  ex_pred_q;
    logic [CTR_BITS-1:0]   ex_ctr;
    logic [CTR_BITS-1:0]   ctr_next;
    logic                  id_ctr_msb;

    // Only the word-aligned index bits of the PC select an entry; the rest are ignored.
    assign pc_idx = bus.id_pc[INDEX_BITS+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.id_pc[PC_WIDTH-1:INDEX_BITS+2], bus.id_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    assign id_idx = pc_idx ^ ghr;

    generate
        if (INDEX_BITS == 1) begin : g_ghr_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr <= '0;
                end else if (bus.ex_update) begin
                    ghr <= bus.ex_taken;
                end
            end
        end else begin : g_ghr_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr <= '0;
                end else if (bus.ex_update) begin
                    ghr <= {ghr[INDEX_BITS-2:0], bus.ex_taken};
                end
            end
        end
    endgenerate
`else
    assign id_idx = pc_idx;
`endif

    // Read sees the pre-update value even when EX writes the same entry this cycle.
    assign id_ctr_msb = ctr[id_idx][CTR_BITS-1];

    always_comb begin
        bus.pred_taken = 1'b0;
        if (!rst) begin
            bus.pred_taken = bus.id_is_branch && id_ctr_msb;
        end
    end

    always_comb begin
        bus.mispredict = 1'b0;
        if (!rst) begin
            bus.mispredict = bus.ex_update && (bus.ex_taken != ex_pred_q);
        end
    end

    assign bus.ex_pred_taken = ex_pred_q;

    // Stall wins over flush; a flushed slot carries no prediction into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pred_q <= 1'b0;
            ex_idx    <= '0;
        end else if (bus.stall) begin
            ex_pred_q <= ex_pred_q;
            ex_idx    <= ex_idx;
        end else if (bus.flush) begin
            ex_pred_q <= 1'b0;
        end else begin
            ex_pred_q <= bus.pred_taken;
            ex_idx    <= id_idx;
        end
    end

    assign ex_ctr = ctr[ex_idx];

    always_comb begin
        ctr_next = ex_ctr;
        if (bus.ex_taken) begin
            if (ex_ctr != CTR_MAX) begin
                ctr_next = ex_ctr + CTR_ONE;
            end
        end else begin
            if (ex_ctr != CTR_MIN) begin
                ctr_next = ex_ctr - CTR_ONE;
            end
        end
    end

    // Updates are independent of stall: the resolving branch already sits in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RST;
            end
        end else if (bus.ex_update) begin
            ctr[ex_idx] <= ctr_next;
        end
    end

endmodule
